// File: rtl/mac_stream_adapter_if.sv
// Operand-stream and result-stream bundle for mac_stream_adapter.
//   s_a/s_b/s_c/s_valid/s_ready : operand beat channel (ready/valid)
//   m_result/m_valid/m_ready    : result channel (ready/valid)
// The slave modport is the adapter's view, the master modport the attached environment's view.
interface mac_stream_adapter_if #(
    parameter int unsigned INPUT_SIZE  = 32,
    parameter int unsigned OUTPUT_SIZE = 2 * INPUT_SIZE
);
    logic [INPUT_SIZE-1:0]  s_a;
    logic [INPUT_SIZE-1:0]  s_b;
    logic [INPUT_SIZE-1:0]  s_c;
    logic                   s_valid;
    logic                   s_ready;
    logic [OUTPUT_SIZE-1:0] m_result;
    logic                   m_valid;
    logic                   m_ready;

    modport slave (
        input  s_a,
        input  s_b,
        input  s_c,
        input  s_valid,
        output s_ready,
        output m_result,
        output m_valid,
        input  m_ready
    );

    modport master (
        output s_a,
        output s_b,
        output s_c,
        output s_valid,
        input  s_ready,
        input  m_result,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/mac_stream_adapter.sv
// Initiator/collector wrapped around a fixed-latency pipelined MAC.
// Operand beats accepted on the slave stream are registered onto the MAC's valid-only input;
// MAC results are captured in a result FIFO and presented on the master stream. Issue is
// credit-limited (in-flight + queued <= FIFO_DEPTH) so a result always finds a free slot.
// Ports:
//   clock, reset_n        : clock (rising edge) and asynchronous active-low reset
//   bus (slave modport)   : s_a/s_b/s_c/s_valid/s_ready in, m_result/m_valid/m_ready out
//   mac_a/mac_b/mac_c     : registered operands to the MAC
//   mac_valid             : registered issue strobe to the MAC
//   mac_result(_valid)    : result returned by the MAC
//   proto_err             : sticky flag for results that were unexpected or had no slot
module mac_stream_adapter #(
    parameter int unsigned INPUT_SIZE  = 32,
    parameter int unsigned OUTPUT_SIZE = 2 * INPUT_SIZE,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    mac_stream_adapter_if.slave    bus,
    output logic [INPUT_SIZE-1:0]  mac_a,
    output logic [INPUT_SIZE-1:0]  mac_b,
    output logic [INPUT_SIZE-1:0]  mac_c,
    output logic                   mac_valid,
    input  logic [OUTPUT_SIZE-1:0] mac_result,
    input  logic                   mac_result_valid,
    output logic                   proto_err
);
    localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    // Storage is rounded up to a power of two so the pointer width always fits the array.
    localparam int unsigned MEM_N = 1 << PW;

    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] ONE_C    = CW'(1);
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

    if (FIFO_DEPTH < 1) begin : g_bad_depth
        $error("mac_stream_adapter: FIFO_DEPTH must be at least 1");
    end
    if (LATENCY < 1) begin : g_bad_latency
        $error("mac_stream_adapter: LATENCY must be at least 1");
    end

    logic [CW-1:0]          r_inflight;
    logic [CW-1:0]          w_inflight_nxt;
    logic [CW-1:0]          r_count;
    logic [CW-1:0]          w_count_nxt;
    logic [PW-1:0]          r_wr_ptr;
    logic [PW-1:0]          w_wr_ptr_nxt;
    logic [PW-1:0]          r_rd_ptr;
    logic [PW-1:0]          w_rd_ptr_nxt;
    logic [OUTPUT_SIZE-1:0] r_mem [MEM_N];
    logic                   r_s_ready;
    logic                   w_s_ready_nxt;
    logic                   r_proto_err;
    logic                   w_proto_err_nxt;
    logic                   r_mac_valid;
    logic [INPUT_SIZE-1:0]  r_mac_a;
    logic [INPUT_SIZE-1:0]  r_mac_b;
    logic [INPUT_SIZE-1:0]  r_mac_c;

    logic                   w_issue;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_write;
    logic                   w_orphan;
    logic                   w_overflow;
    logic                   w_retire;
    logic [CW:0]            w_used_nxt;

    function automatic logic [PW-1:0] f_next_ptr(input logic [PW-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PW'(1);
    endfunction

    // Handshake and event decode.
    always_comb begin
        w_issue    = bus.s_valid && r_s_ready;
        w_pop      = (r_count != '0) && bus.m_ready;
        w_full     = (r_count == DEPTH_C);
        // A pop in the same cycle frees the head slot, so a full FIFO can still take a write.
        w_write    = mac_result_valid && (!w_full || w_pop);
        w_orphan   = mac_result_valid && (r_inflight == '0);
        w_overflow = mac_result_valid && w_full && !w_pop;
        // An orphan result does not retire anything: the in-flight count never goes negative.
        w_retire   = mac_result_valid && !w_orphan;
    end

    // In-flight counter.
    always_comb begin
        w_inflight_nxt = r_inflight;
        case ({w_issue, w_retire})
            2'b10:   w_inflight_nxt = r_inflight + ONE_C;
            2'b01:   w_inflight_nxt = r_inflight - ONE_C;
            default: w_inflight_nxt = r_inflight;
        endcase
    end

    // FIFO occupancy and pointers.
    always_comb begin
        w_count_nxt  = r_count;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        case ({w_write, w_pop})
            2'b10:   w_count_nxt = r_count + ONE_C;
            2'b01:   w_count_nxt = r_count - ONE_C;
            default: w_count_nxt = r_count;
        endcase
        if (w_write) begin
            w_wr_ptr_nxt = f_next_ptr(r_wr_ptr);
        end
        if (w_pop) begin
            w_rd_ptr_nxt = f_next_ptr(r_rd_ptr);
        end
    end

    // Credit and error next state. s_ready is registered from the next-state credit use, so it
    // is a pure register output and a pop only frees its credit from the following cycle.
    always_comb begin
        w_used_nxt      = {1'b0, w_inflight_nxt} + {1'b0, w_count_nxt};
        w_s_ready_nxt   = (w_used_nxt < {1'b0, DEPTH_C});
        w_proto_err_nxt = r_proto_err || w_overflow || w_orphan;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_inflight  <= '0;
            r_count     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_s_ready   <= 1'b0;
            r_proto_err <= 1'b0;
            r_mac_valid <= 1'b0;
            r_mac_a     <= '0;
            r_mac_b     <= '0;
            r_mac_c     <= '0;
        end else begin
            r_inflight  <= w_inflight_nxt;
            r_count     <= w_count_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_s_ready   <= w_s_ready_nxt;
            r_proto_err <= w_proto_err_nxt;
            r_mac_valid <= w_issue;
            // Operands hold their last issued value when nothing is issued.
            if (w_issue) begin
                r_mac_a <= bus.s_a;
                r_mac_b <= bus.s_b;
                r_mac_c <= bus.s_c;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MEM_N; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_write) begin
            r_mem[r_wr_ptr] <= mac_result;
        end
    end

    assign bus.s_ready  = r_s_ready;
    assign bus.m_valid  = (r_count != '0);
    assign bus.m_result = r_mem[r_rd_ptr];
    assign mac_a        = r_mac_a;
    assign mac_b        = r_mac_b;
    assign mac_c        = r_mac_c;
    assign mac_valid    = r_mac_valid;
    assign proto_err    = r_proto_err;
endmodule

// File: tb/tb_mac_stream_adapter.sv
// Self-checking bench for mac_stream_adapter: a behavioural MAC drives the result side, and a
// transaction-level scoreboard (expected result queue plus outstanding-beat count) checks
// ordering, data, credit flow control and issue behaviour. A second adapter (depth 1) sits on
// a slower MAC with foreign-traffic injection to exercise the protocol-error flag.
module tb_mac_stream_adapter;
    localparam int unsigned IW    = 32;
    localparam int unsigned OW    = 64;
    localparam int unsigned DEPTH = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset_n = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- main DUT: LATENCY 2, DEPTH 4, MAC STAGES 2 ----------------
    mac_stream_adapter_if #(.INPUT_SIZE(IW), .OUTPUT_SIZE(OW)) bus ();
    logic [IW-1:0] mac_a, mac_b, mac_c;
    logic          mac_valid;
    logic [OW-1:0] mac_result;
    logic          mac_result_valid;
    logic          proto_err;

    mac_stream_adapter #(
        .INPUT_SIZE (IW),
        .OUTPUT_SIZE(OW),
        .LATENCY    (2),
        .FIFO_DEPTH (DEPTH)
    ) u_dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .bus             (bus),
        .mac_a           (mac_a),
        .mac_b           (mac_b),
        .mac_c           (mac_c),
        .mac_valid       (mac_valid),
        .mac_result      (mac_result),
        .mac_result_valid(mac_result_valid),
        .proto_err       (proto_err)
    );

    function automatic logic [OW-1:0] mac_fn(input logic [IW-1:0] a, input logic [IW-1:0] b,
                                             input logic [IW-1:0] c);
        longint r;
        r = longint'($signed(a)) * longint'($signed(b)) + longint'($signed(c));
        return r;
    endfunction

    function automatic logic [OW-1:0] s64(input longint v);
        return v;
    endfunction

    logic [OW-1:0] p_res [2];
    logic          p_vld [2];
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            p_vld[0] <= 1'b0;
            p_vld[1] <= 1'b0;
            p_res[0] <= '0;
            p_res[1] <= '0;
        end else begin
            p_vld[0] <= mac_valid;
            p_res[0] <= mac_fn(mac_a, mac_b, mac_c);
            p_vld[1] <= p_vld[0];
            p_res[1] <= p_res[0];
        end
    end
    assign mac_result       = p_res[1];
    assign mac_result_valid = p_vld[1];

    // ---------------- second DUT: LATENCY 2, DEPTH 1, MAC STAGES 3 ----------------
    mac_stream_adapter_if #(.INPUT_SIZE(IW), .OUTPUT_SIZE(OW)) bus2 ();
    logic [IW-1:0] mac2_a, mac2_b, mac2_c;
    logic          mac2_valid;
    logic [OW-1:0] mac2_result;
    logic          mac2_result_valid;
    logic          proto_err2;
    logic          inj = 1'b0;
    logic [IW-1:0] inj_a = '0, inj_b = '0, inj_c = '0;

    mac_stream_adapter #(
        .INPUT_SIZE (IW),
        .OUTPUT_SIZE(OW),
        .LATENCY    (2),
        .FIFO_DEPTH (1)
    ) u_dut2 (
        .clock           (clock),
        .reset_n         (reset_n),
        .bus             (bus2),
        .mac_a           (mac2_a),
        .mac_b           (mac2_b),
        .mac_c           (mac2_c),
        .mac_valid       (mac2_valid),
        .mac_result      (mac2_result),
        .mac_result_valid(mac2_result_valid),
        .proto_err       (proto_err2)
    );

    logic [OW-1:0] q_res [3];
    logic          q_vld [3];
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                q_vld[i] <= 1'b0;
                q_res[i] <= '0;
            end
        end else begin
            q_vld[0] <= mac2_valid || inj;
            q_res[0] <= inj ? mac_fn(inj_a, inj_b, inj_c) : mac_fn(mac2_a, mac2_b, mac2_c);
            for (int i = 1; i < 3; i++) begin
                q_vld[i] <= q_vld[i-1];
                q_res[i] <= q_res[i-1];
            end
        end
    end
    assign mac2_result       = q_res[2];
    assign mac2_result_valid = q_vld[2];

    // ---------------- checking and scoreboard ----------------
    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [OW-1:0]   exp_q [$];
    logic [OW-1:0]   got_q [$];
    int              outstanding;
    int              cyc;
    int              arrivals;
    logic            prev_acc;
    logic            prev_hold;
    logic [3*IW-1:0] prev_abc;
    logic [3*IW-1:0] last_abc;
    logic [OW-1:0]   prev_res;

    task automatic model_reset();
        exp_q.delete();
        outstanding = 0;
        arrivals    = 0;
        prev_acc    = 1'b0;
        prev_hold   = 1'b0;
        prev_abc    = '0;
        last_abc    = '0;
        prev_res    = '0;
    endtask

    // Called at a falling edge with inputs already driven; scores this cycle, then advances.
    task automatic step();
        logic            acc;
        logic            pop;
        logic [3*IW-1:0] abc;
        acc = bus.s_valid && bus.s_ready;
        pop = bus.m_valid && bus.m_ready;
        abc = {bus.s_a, bus.s_b, bus.s_c};
        // Every accepted-but-unpopped beat holds a credit.
        check_eq("s_ready_credit", bus.s_ready, outstanding < DEPTH);
        check_eq("proto_err_clean", proto_err, 0);
        check_eq("m_valid_spurious", bus.m_valid && (outstanding == 0), 0);
        if (prev_acc) begin
            check_eq("mac_valid_issue", mac_valid, 1);
            check_eq("mac_operands", {mac_a, mac_b, mac_c}, prev_abc);
        end else begin
            check_eq("mac_valid_idle", mac_valid, 0);
            check_eq("mac_operands_hold", {mac_a, mac_b, mac_c}, last_abc);
        end
        if (prev_hold) begin
            check_eq("m_valid_hold", bus.m_valid, 1);
            check_eq("m_result_hold", bus.m_result, prev_res);
        end
        if (mac_result_valid) arrivals++;
        if (pop) begin
            got_q.push_back(bus.m_result);
            check_eq("pop_has_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check_eq("m_result", bus.m_result, exp_q.pop_front());
            outstanding--;
        end
        if (acc) begin
            exp_q.push_back(mac_fn(bus.s_a, bus.s_b, bus.s_c));
            outstanding++;
            last_abc = abc;
        end
        prev_acc  = acc;
        prev_abc  = abc;
        prev_hold = bus.m_valid && !bus.m_ready;
        prev_res  = bus.m_result;
        cyc++;
        @(negedge clock);
    endtask

    task automatic offer(input logic [IW-1:0] a, input logic [IW-1:0] b, input logic [IW-1:0] c,
                         output logic acc);
        bus.s_valid = 1'b1;
        bus.s_a     = a;
        bus.s_b     = b;
        bus.s_c     = c;
        acc         = bus.s_ready;
        step();
        bus.s_valid = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        bus.m_ready = 1'b1;
        for (int i = 0; i < max_cycles; i++) step();
        bus.m_ready = 1'b0;
    endtask

    task automatic apply_reset();
        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_m_valid", bus.m_valid, 0);
        check_eq("rst_mac_valid", mac_valid, 0);
        check_eq("rst_s_ready", bus.s_ready, 0);
        check_eq("rst_proto_err", proto_err, 0);
        check_eq("rst_mac_operands", {mac_a, mac_b, mac_c}, 0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        @(negedge clock);
    endtask

    function automatic logic [IW-1:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'h7fff_ffff;
            2:       return '0;
            3:       return '1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          acc;
        int            t0;
        int            base;
        int            idx;
        logic          found;
        logic [IW-1:0] bp_a [6];
        logic [IW-1:0] bp_b [6];
        logic [IW-1:0] bp_c [6];
        logic [OW-1:0] first_exp;

        bus.s_valid  = 1'b0;
        bus.s_a      = '0;
        bus.s_b      = '0;
        bus.s_c      = '0;
        bus.m_ready  = 1'b0;
        bus2.s_valid = 1'b0;
        bus2.s_a     = '0;
        bus2.s_b     = '0;
        bus2.s_c     = '0;
        bus2.m_ready = 1'b0;
        cyc          = 0;
        model_reset();
        apply_reset();

        // 1. Streaming with downstream always ready.
        bus.m_ready = 1'b1;
        base = got_q.size();
        t0   = cyc;
        check_eq("stream_s_ready0", bus.s_ready, 1);
        offer(3, 4, 5, acc);
        check_eq("stream_s_ready1", bus.s_ready, 1);
        offer(-2, 7, 1, acc);
        check_eq("stream_s_ready2", bus.s_ready, 1);
        offer(0, 9, -6, acc);
        for (int i = 0; i < 10 && !bus.m_valid; i++) step();
        // Sample t0+4 is the one just after edge k+3 (accept at edge k).
        check_eq("stream_latency", cyc - t0, 4);
        for (int i = 0; i < 3; i++) begin
            check_eq("stream_back_to_back", bus.m_valid, 1);
            step();
        end
        check_eq("stream_done", bus.m_valid, 0);
        check_eq("stream_count", got_q.size() - base, 3);
        if (got_q.size() - base == 3) begin
            check_eq("stream_r0", got_q[base], s64(17));
            check_eq("stream_r1", got_q[base+1], s64(-13));
            check_eq("stream_r2", got_q[base+2], s64(-6));
        end
        bus.m_ready = 1'b0;

        // 2. Backpressure: six beats offered, only four fit.
        for (int i = 0; i < 6; i++) begin
            bp_a[i] = rand_op();
            bp_b[i] = rand_op();
            bp_c[i] = rand_op();
        end
        first_exp = mac_fn(bp_a[0], bp_b[0], bp_c[0]);
        base = got_q.size();
        idx  = 0;
        for (int i = 0; i < 12; i++) begin
            if (idx < 6) begin
                offer(bp_a[idx], bp_b[idx], bp_c[idx], acc);
                if (acc) idx++;
            end else begin
                step();
            end
        end
        check_eq("bp_accepted", idx, 4);
        check_eq("bp_s_ready_low", bus.s_ready, 0);
        check_eq("bp_m_valid", bus.m_valid, 1);
        check_eq("bp_head", bus.m_result, first_exp);
        bus.m_ready = 1'b1;
        check_eq("bp_s_ready_at_pop", bus.s_ready, 0);
        step();
        check_eq("bp_s_ready_after_pop", bus.s_ready, 1);
        drain(6);
        check_eq("bp_popped", got_q.size() - base, 4);

        // 3. Three queued, one in flight; pop on the cycle the last result lands.
        arrivals = 0;
        for (int i = 0; i < 4; i++) begin
            offer(rand_op(), rand_op(), rand_op(), acc);
            check_eq("fp_accept", acc, 1);
        end
        for (int i = 0; i < 20; i++) begin
            if (mac_result_valid && arrivals == 3) break;
            step();
        end
        found = mac_result_valid && (arrivals == 3);
        check_eq("fp_found", found, 1);
        bus.m_ready = 1'b1;
        step();
        bus.m_ready = 1'b0;
        step();
        base = got_q.size();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 10 && bus.m_valid; i++) step();
        bus.m_ready = 1'b0;
        check_eq("fp_remaining", got_q.size() - base, 3);
        check_eq("fp_proto_err", proto_err, 0);

        // 4. Extreme operands.
        base = got_q.size();
        bus.m_ready = 1'b1;
        offer(32'h8000_0000, 32'h8000_0000, 32'hffff_ffff, acc);
        offer(32'h7fff_ffff, 32'h0000_0001, 32'h0000_0000, acc);
        drain(8);
        check_eq("ext_count", got_q.size() - base, 2);
        if (got_q.size() - base == 2) begin
            check_eq("ext_min_sq", got_q[base], s64(64'sh3fff_ffff_ffff_ffff));
            check_eq("ext_max", got_q[base+1], s64(64'sh0000_0000_7fff_ffff));
        end

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            bus.s_valid = ($urandom_range(0, 3) != 0);
            bus.s_a     = rand_op();
            bus.s_b     = rand_op();
            bus.s_c     = rand_op();
            bus.m_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        bus.s_valid = 1'b0;
        drain(20);
        check_eq("rand_drained_q", exp_q.size(), 0);
        check_eq("rand_drained_out", outstanding, 0);

        // 5. Reset with two queued and two in flight.
        for (int i = 0; i < 4; i++) offer(rand_op(), rand_op(), rand_op(), acc);
        step();
        check_eq("rst_mid_queued", bus.m_valid, 1);
        apply_reset();
        check_eq("rst_mid_s_ready", bus.s_ready, 1);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check_eq("rst_no_stale", bus.m_valid, 0);
            step();
        end
        bus.m_ready = 1'b0;

        // 6. Depth-1 adapter on a slower MAC, plus foreign results.
        check_eq("mm_s_ready_idle", bus2.s_ready, 1);
        bus2.s_a     = 3;
        bus2.s_b     = 4;
        bus2.s_c     = 5;
        bus2.s_valid = 1'b1;
        @(negedge clock);
        bus2.s_valid = 1'b0;
        check_eq("mm_s_ready_busy", bus2.s_ready, 0);
        for (int i = 0; i < 10 && !bus2.m_valid; i++) @(negedge clock);
        check_eq("mm_first_valid", bus2.m_valid, 1);
        check_eq("mm_first_result", bus2.m_result, s64(17));
        check_eq("mm_no_err_yet", proto_err2, 0);
        inj_a = 2;
        inj_b = 2;
        inj_c = 2;
        inj   = 1'b1;
        @(negedge clock);
        inj = 1'b0;
        repeat (6) @(negedge clock);
        check_eq("mm_drop_err", proto_err2, 1);
        check_eq("mm_head_kept", bus2.m_result, s64(17));
        bus2.m_ready = 1'b1;
        @(negedge clock);
        bus2.m_ready = 1'b0;
        @(negedge clock);
        check_eq("mm_dropped_gone", bus2.m_valid, 0);
        inj_a = 5;
        inj_b = -3;
        inj_c = 1;
        inj   = 1'b1;
        @(negedge clock);
        inj = 1'b0;
        for (int i = 0; i < 10 && !bus2.m_valid; i++) @(negedge clock);
        check_eq("mm_orphan_written", bus2.m_valid, 1);
        check_eq("mm_orphan_result", bus2.m_result, s64(-14));
        repeat (5) @(negedge clock);
        check_eq("mm_err_sticky", proto_err2, 1);
        check_eq("mm_s_ready_blocked", bus2.s_ready, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
